// File: rtl/seq_div.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
// Optional zero-divisor / overflow early exit enabled by defining SEQ_DIV_ERR_CHECK_EN.
`timescale 1ns / 1ps

module seq_div #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0]   inputB,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               done,
  output logic               busy,
  output logic               divz,
  output logic               ovf
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             done_q, done_d;

  logic             accept;
  logic             calc_last;
  logic             err_hit;

  // One restoring step on the current partial remainder / quotient pair.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quo_step;

  always_comb begin
    rem_sh   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    trial    = {1'b0, rem_sh} - {2'b00, div_q};
    rem_step = trial[WIDTH+1] ? rem_sh : trial[WIDTH:0];
    quo_step = {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
  end

  assign accept    = (state_q == StIdle) && start;
  assign calc_last = (state_q == StCalc) && (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          rem_d = {1'b0, inputA[2*WIDTH-1:WIDTH]};
          quo_d = inputA[WIDTH-1:0];
          div_d = inputB;
          cnt_d = '0;
          if (err_hit) begin
            state_d     = StDone;
            done_d      = 1'b1;
            quotient_d  = '1;
            remainder_d = '0;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 1'b1;
        if (calc_last) begin
          state_d     = StDone;
          done_d      = 1'b1;
          quotient_d  = quo_step;
          remainder_d = rem_step[WIDTH-1:0];
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
    end
  end

`ifdef SEQ_DIV_ERR_CHECK_EN
  logic err_divz;
  logic err_ovf;
  logic divz_q, divz_d;
  logic ovf_q, ovf_d;

  // A high half not below the divisor would need more than WIDTH quotient bits.
  assign err_divz = (inputB == '0);
  assign err_ovf  = !err_divz && (inputA[2*WIDTH-1:WIDTH] >= inputB);
  assign err_hit  = err_divz || err_ovf;

  always_comb begin
    divz_d = divz_q;
    ovf_d  = ovf_q;
    if (accept && err_hit) begin
      divz_d = err_divz;
      ovf_d  = err_ovf;
    end else if (calc_last) begin
      divz_d = 1'b0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divz_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      divz_q <= divz_d;
      ovf_q  <= ovf_d;
    end
  end

  assign divz = divz_q;
  assign ovf  = ovf_q;
`else
  assign err_hit = 1'b0;
  assign divz    = 1'b0;
  assign ovf     = 1'b0;
`endif

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign done      = done_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: arithmetic reference model (A/B, A%B, fixed latency) checked every cycle,
// plus directed literal cases for the documented scenarios.
`timescale 1ns / 1ps

module tb_seq_div;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [2*W-1:0] inputA = '0;
  logic [W-1:0]   inputB = '0;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           done;
  logic           busy;
  logic           divz;
  logic           ovf;

  seq_div #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .inputA    (inputA),
    .inputB    (inputB),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done),
    .busy      (busy),
    .divz      (divz),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: m_rem counts the busy cycles still owed by the accepted operation.
  int         m_rem;
  logic [W-1:0] m_q, m_r, p_q, p_r;
  logic         m_divz, m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  <= 0;
      m_q    <= '0;
      m_r    <= '0;
      m_divz <= 1'b0;
      m_ovf  <= 1'b0;
      p_q    <= '0;
      p_r    <= '0;
    end else if (m_rem == 0) begin
      if (start) begin
`ifdef SEQ_DIV_ERR_CHECK_EN
        if (inputB == 0) begin
          m_rem <= 1; m_q <= '1; m_r <= '0; m_divz <= 1'b1; m_ovf <= 1'b0;
        end else if (inputA[2*W-1:W] >= inputB) begin
          m_rem <= 1; m_q <= '1; m_r <= '0; m_divz <= 1'b0; m_ovf <= 1'b1;
        end else
`endif
        begin
          m_rem <= W + 1;
          p_q   <= W'(inputA / inputB);
          p_r   <= W'(inputA % inputB);
        end
      end
    end else begin
      m_rem <= m_rem - 1;
      if (m_rem == 2) begin
        m_q    <= p_q;
        m_r    <= p_r;
        m_divz <= 1'b0;
        m_ovf  <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", busy, m_rem > 0);
      check("done", done, m_rem == 1);
      check("quotient", quotient, m_q);
      check("remainder", remainder, m_r);
      check("divz", divz, m_divz);
      check("ovf", ovf, m_ovf);
    end
  end

  logic [W-1:0] r_q, r_r;
  logic         r_dz, r_ov;
  int           r_lat;
  int           ndone, kdone, cyc, guard;
  int           tdone [3];

  task automatic run_op(input logic [2*W-1:0] a, input logic [W-1:0] b);
    int g = 0;
    while (busy && g < 50) begin
      @(negedge clk);
      g++;
    end
    inputA = a;
    inputB = b;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    r_lat = 1;
    while (!done && r_lat < 50) begin
      @(negedge clk);
      r_lat++;
    end
    if (!done) check("op_timeout_done", done, 1);
    r_q  = quotient;
    r_r  = remainder;
    r_dz = divz;
    r_ov = ovf;
  endtask

  task automatic gen_operands(output logic [2*W-1:0] a, output logic [W-1:0] b);
    logic [W-1:0] hi;
    b  = W'($urandom_range(1, 255));
    hi = W'($urandom_range(0, int'(b) - 1));
`ifdef SEQ_DIV_ERR_CHECK_EN
    if ($urandom_range(0, 15) == 0) begin
      if ($urandom_range(0, 1) == 1) b = '0;
      else hi = W'($urandom_range(int'(b), 255));
    end
`endif
    a = {hi, W'($urandom)};
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_divz", divz, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'd100, 8'd7);
    check("q_100_7", r_q, 14);
    check("r_100_7", r_r, 2);
    check("lat_100_7", r_lat, 9);
    check("divz_100_7", r_dz, 0);
    check("ovf_100_7", r_ov, 0);

    run_op(16'hFEFF, 8'hFF);
    check("q_feff_ff", r_q, 8'hFF);
    check("r_feff_ff", r_r, 8'hFE);
    check("lat_feff_ff", r_lat, 9);

`ifdef SEQ_DIV_ERR_CHECK_EN
    run_op(16'h1234, 8'd0);
    check("lat_divz", r_lat, 1);
    check("divz_flag", r_dz, 1);
    check("divz_ovf", r_ov, 0);
    check("divz_q", r_q, 8'hFF);
    check("divz_r", r_r, 0);

    run_op(16'h0100, 8'd1);
    check("lat_ovf", r_lat, 1);
    check("ovf_flag", r_ov, 1);
    check("ovf_divz", r_dz, 0);
    check("ovf_q", r_q, 8'hFF);
`endif

    // start pulses while busy (including the done cycle) must be ignored
    @(negedge clk);
    inputA = 16'd3000;
    inputB = 8'd45;
    start  = 1'b1;
    ndone  = 0;
    kdone  = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start = (k == 2 || k == 5 || k == 9);
      if (start) begin
        inputA = 16'd77;
        inputB = 8'd3;
      end
      if (done) begin
        ndone++;
        kdone = k;
        r_q   = quotient;
        r_r   = remainder;
      end
    end
    start = 1'b0;
    check("ignore_done_count", ndone, 1);
    check("ignore_done_cycle", kdone, 9);
    check("ignore_q", r_q, 66);
    check("ignore_r", r_r, 30);

    // async reset during step 4 of CALC aborts the operation
    inputA = 16'd12345;
    inputB = 8'd99;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_op(16'd12345, 8'd99);
    check("after_abort_q", r_q, 124);
    check("after_abort_r", r_r, 69);
    check("after_abort_lat", r_lat, 9);

    // start held high: back-to-back accepts every W+2 cycles
    @(negedge clk);
    inputA = 16'd5000;
    inputB = 8'd100;
    start  = 1'b1;
    cyc    = 0;
    ndone  = 0;
    guard  = 0;
    while (ndone < 3 && guard < 60) begin
      @(negedge clk);
      cyc++;
      guard++;
      if (done) begin
        tdone[ndone] = cyc;
        case (ndone)
          0: begin
            check("held_q0", quotient, 50);
            check("held_r0", remainder, 0);
            inputA = 16'd1000;
            inputB = 8'd7;
          end
          1: begin
            check("held_q1", quotient, 142);
            check("held_r1", remainder, 6);
            inputA = 16'd65000;
            inputB = 8'd254;
          end
          default: begin
            check("held_q2", quotient, 255);
            check("held_r2", remainder, 230);
            start = 1'b0;
          end
        endcase
        ndone++;
      end
    end
    start = 1'b0;
    check("held_done_count", ndone, 3);
    check("held_first_done", tdone[0], 9);
    check("held_spacing_1", tdone[1] - tdone[0], W + 2);
    check("held_spacing_2", tdone[2] - tdone[1], W + 2);
    @(negedge clk);
    check("held_done_single", done, 0);

    // random traffic; the per-cycle compare process does the checking
    repeat (40000) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) != 0);
      gen_operands(inputA, inputB);
    end
    start = 1'b0;
    repeat (15) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
